// File: rtl/serial_arith_defs.sv
// rtl/serial_arith_defs.sv - shared state and mode encodings for the serial arithmetic blocks
package serial_arith_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_if.sv
// rtl/serial_add_sub_if.sv - start/busy/done operation interface of the serial adder/subtractor
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             cout_bout;
  logic             overflow;
  logic             busy;
  logic             done;

  // controller side: issues operations, consumes results
  modport master (
    output start, mode, a, b,
    input  result, cout_bout, overflow, busy, done
  );

  // arithmetic unit side
  modport slave (
    input  start, mode, a, b,
    output result, cout_bout, overflow, busy, done
  );

endinterface

// File: rtl/add_sub_cell.sv
// rtl/add_sub_cell.sv - 1-bit full adder / full subtractor cell
module add_sub_cell
  import serial_arith_defs::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic mode,
  output logic s,
  output logic cout
);

  // sum and difference bits are the same three-input parity
  assign s = a ^ b ^ cin;

  // carry for add, borrow for subtract
  assign cout = (mode == MODE_SUB) ? ((~a & b) | (cin & ~(a ^ b)))
                                   : ((a & b) | (cin & (a ^ b)));

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial LSB-first adder/subtractor with start/busy/done handshake
module serial_add_sub
  import serial_arith_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_sub_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // holds the WIDTH-1 result bits already produced; the newest bit enters at the top
  logic [WIDTH-2:0] res_sh;
  logic             mode_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic             cell_s;
  logic             cell_c;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;
  logic             last_bit;

  add_sub_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .mode (mode_r),
    .s    (cell_s),
    .cout (cell_c)
  );

  assign res_next = {cell_s, res_sh};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // signed overflow from the latched operand sign bits and the final result bit
  always_comb begin
    ovf_next = 1'b0;
    if (mode_r == MODE_SUB) begin
      ovf_next = (a_msb != b_msb) && (cell_s != a_msb);
    end else begin
      ovf_next = (a_msb == b_msb) && (cell_s != a_msb);
    end
  end

  // control FSM, operand/result shifting and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      mode_r   <= 1'b0;
      carry    <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      result_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            mode_r <= bus.mode;
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
            carry  <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= ST_SHIFT;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next[WIDTH-1:1];
          carry  <= cell_c;
          if (last_bit) begin
            // counter parks at WIDTH-1 rather than wrapping
            result_r <= res_next;
            cout_r   <= cell_c;
            ovf_r    <= ovf_next;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.result    = result_r;
  assign bus.cout_bout = cout_r;
  assign bus.overflow  = ovf_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule
